// File: rtl/alu_shift_iter.sv
// alu_shift_iter
//   Shift/rotate unit. Plain shifts and PASS complete on the accept edge;
//   funnel shifts and rotates walk a double-width work register STEP bits
//   per cycle until the requested amount has been applied.
//
// Ports
//   clk      in   clock, all state on the rising edge
//   reset    in   synchronous active-high reset
//   a        in   WIDTH  primary operand (high word for funnel ops)
//   b        in   WIDTH  low word for funnel ops
//   shamt    in   SHW    shift/rotate amount
//   funct    in   3      operation select
//   valid_i  in   request valid
//   ready_o  out  request ready (high only while idle)
//   result   out  WIDTH  registered result
//   valid_o  out  response valid (high only while holding a result)
//   ready_i  in   response ready
module alu_shift_iter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    input  logic [2:0]       funct,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] result,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] F_SHL  = 3'b000;
    localparam logic [2:0] F_SHR  = 3'b001;
    localparam logic [2:0] F_ASHR = 3'b010;
    localparam logic [2:0] F_FSHR = 3'b011;
    localparam logic [2:0] F_FSHL = 3'b100;
    localparam logic [2:0] F_ROR  = 3'b110;

    // Count is one bit wider than shamt so that STEP == WIDTH is representable.
    localparam logic [SHW:0] STEP_C = (SHW + 1)'(STEP);

    logic [1:0]         state;
    logic [2*WIDTH-1:0] work;
    logic [SHW:0]       cnt;
    logic               right;

    logic [WIDTH-1:0]   quick;
    logic               iterative;
    logic [SHW:0]       amt;
    logic [SHW:0]       remain;
    logic [2*WIDTH-1:0] shifted;

    // Single-cycle results; funnel/rotate ops only land here with shamt == 0.
    always_comb begin
        quick = a;
        case (funct)
            F_SHL:   quick = a << shamt;
            F_SHR:   quick = a >> shamt;
            F_ASHR:  quick = $signed(a) >>> shamt;
            F_FSHR:  quick = b;
            default: quick = a;
        endcase
    end

    always_comb begin
        iterative = (funct >= F_FSHR) && (funct <= F_ROR) && (shamt != '0);
        amt       = (cnt > STEP_C) ? STEP_C : cnt;
        remain    = cnt - amt;
        shifted   = right ? (work >> amt) : (work << amt);
    end

    // Rotates load {a,a}: since the total shift stays below WIDTH, the bits
    // shifted out of one half are always supplied by the copy in the other.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            work   <= '0;
            cnt    <= '0;
            right  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (iterative) begin
                            work  <= (funct == F_FSHR || funct == F_FSHL) ? {a, b} : {a, a};
                            cnt   <= {1'b0, shamt};
                            right <= (funct == F_FSHR) || (funct == F_ROR);
                            state <= ITER;
                        end else begin
                            result <= quick;
                            state  <= DONE;
                        end
                    end
                end
                ITER: begin
                    work <= shifted;
                    cnt  <= remain;
                    if (remain == '0) begin
                        result <= right ? shifted[WIDTH-1:0] : shifted[2*WIDTH-1:WIDTH];
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);

endmodule

// File: tb/tb_alu_shift_iter.sv
// tb_alu_shift_iter
//   Directed bench for alu_shift_iter (WIDTH=32, STEP=4). Expected results
//   and latencies are queued at issue time; a monitor pops and compares on
//   each consumed response.
module tb_alu_shift_iter;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [2:0]       funct;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] result;
    logic             valid_o;
    logic             ready_i;

    alu_shift_iter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .shamt   (shamt),
        .funct   (funct),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .result  (result),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               lat;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge.
    initial begin : monitor
        int   acc;
        int   first;
        logic prev;
        exp_t e;
        acc   = 0;
        first = 0;
        prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (valid_i && ready_o) acc = cyc;
                if (valid_o && !prev) first = cyc;
                if (valid_o && ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_response: got result=%h with no op outstanding", result);
                    end else begin
                        e = exp_q.pop_front();
                        if (result !== e.res) begin
                            errors++;
                            $display("FAIL %s result: got %h expected %h", e.name, result, e.res);
                        end
                        checks++;
                        if (first - acc != e.lat) begin
                            errors++;
                            $display("FAIL %s latency: got %0d expected %0d", e.name, first - acc, e.lat);
                        end
                    end
                end
                prev = valid_o;
            end
        end
    end

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Present one request; returns one cycle after the transfer edge with
    // the operand inputs scrambled so late capture would be visible.
    task automatic issue(input logic [2:0] f, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic [SHW-1:0] sh);
        int n;
        n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: ready_o=%b expected 1", ready_o);
        end
        funct   = f;
        a       = av;
        b       = bv;
        shamt   = sh;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        a       = 32'hDEAD_BEEF;
        b       = 32'hCAFE_F00D;
        shamt   = 5'd17;
        funct   = 3'b111;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: outstanding=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic [SHW-1:0] sh,
                          input logic [WIDTH-1:0] expv, input int lat);
        exp_t e;
        e.res  = expv;
        e.lat  = lat;
        e.name = nm;
        exp_q.push_back(e);
        issue(f, av, bv, sh);
        wait_drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   n;
        exp_t e;
        reset   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        a       = '0;
        b       = '0;
        shamt   = '0;
        funct   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_result",  result,  32'h0);
        chk("reset_valid_o", {31'b0, valid_o}, 32'h0);
        chk("reset_ready_o", {31'b0, ready_o}, 32'h1);

        run_op("shl_31",     3'b000, 32'h0000_0001, 32'h0,          5'd31, 32'h8000_0000, 1);
        run_op("ashr_4",     3'b010, 32'h8000_0000, 32'h0,          5'd4,  32'hF800_0000, 1);
        run_op("shr_4",      3'b001, 32'h8000_0000, 32'h0,          5'd4,  32'h0800_0000, 1);
        run_op("ashr_pos",   3'b010, 32'h7FFF_FFFF, 32'h0,          5'd31, 32'h0000_0000, 1);
        run_op("fshr_8",     3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8,  32'h789A_BCDE, 3);
        run_op("fshl_8",     3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8,  32'h3456_789A, 3);
        run_op("rol_5",      3'b101, 32'h8000_0001, 32'h0,          5'd5,  32'h0000_0030, 3);
        run_op("ror_0",      3'b110, 32'h0000_0001, 32'h0,          5'd0,  32'h0000_0001, 1);
        run_op("fshr_0",     3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0,  32'h9ABC_DEF0, 1);
        run_op("fshl_0",     3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0,  32'h1234_5678, 1);
        run_op("rol_3",      3'b101, 32'h1234_5678, 32'h0,          5'd3,  32'h91A2_B3C0, 2);
        run_op("ror_31",     3'b110, 32'h0000_0001, 32'h0,          5'd31, 32'h0000_0002, 9);
        run_op("pass",       3'b111, 32'hA5A5_5A5A, 32'h0,          5'd9,  32'hA5A5_5A5A, 1);

        // Backpressure: hold the response while new requests are offered.
        e.res  = 32'h0000_0030;
        e.lat  = 3;
        e.name = "bp_rol_5";
        exp_q.push_back(e);
        ready_i = 1'b0;
        issue(3'b101, 32'h8000_0001, 32'h0, 5'd5);
        n = 0;
        while (!valid_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid_seen", {31'b0, valid_o}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            valid_i = ~valid_i;
            a       = $urandom;
            b       = $urandom;
            shamt   = 5'($urandom_range(0, 31));
            funct   = 3'b111;
            @(posedge clk); #1;
            chk("bp_result",  result, 32'h0000_0030);
            chk("bp_valid_o", {31'b0, valid_o}, 32'h1);
            chk("bp_ready_o", {31'b0, ready_o}, 32'h0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        wait_drain();
        chk("bp_idle_ready_o", {31'b0, ready_o}, 32'h1);
        chk("bp_idle_valid_o", {31'b0, valid_o}, 32'h0);

        // Reset in the middle of a long rotate: no response may appear.
        issue(3'b110, 32'h0000_0001, 32'h0, 5'd31);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_valid_o", {31'b0, valid_o}, 32'h0);
        chk("abort_result",  result, 32'h0);
        chk("abort_ready_o", {31'b0, ready_o}, 32'h1);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_valid", {31'b0, valid_o}, 32'h0);
        run_op("post_abort_ror", 3'b110, 32'h0000_0001, 32'h0, 5'd31, 32'h0000_0002, 9);
        run_op("post_abort_fshr", 3'b011, 32'hFFFF_0000, 32'h0000_FFFF, 5'd16, 32'h0000_0000, 5);

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: outstanding=%0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_shift_iter.md
ALU_SHIFT_ITER -- requirements
Module: alu_shift_iter

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two, >= 8.
REQ-002 Parameter STEP, default 4, bits shifted per iteration cycle; SHALL be a power of two, 1..WIDTH.
REQ-003 Derived SHW = log2(WIDTH); shift amount width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 a  input  WIDTH  primary operand; high word for funnel ops.
REQ-007 b  input  WIDTH  low word for funnel ops; ignored otherwise.
REQ-008 shamt  input  SHW  shift/rotate amount, 0..WIDTH-1.
REQ-009 funct  input  3  op select (REQ-013).
REQ-010 valid_i / ready_o  input 1 / output 1  request handshake; transfer when both high on a rising edge.
REQ-011 result  output  WIDTH  registered result.
REQ-012 valid_o / ready_i  output 1 / input 1  response handshake; consumed when both high on a rising edge.

Function
REQ-013 funct encoding:
- 000 SHL: a << shamt
- 001 SHR: a >> shamt (zero fill)
- 010 ASHR: a >>> shamt (sign fill)
- 011 FSHR: low WIDTH bits of {a,b} >> shamt
- 100 FSHL: high WIDTH bits of {a,b} << shamt
- 101 ROL: a rotated left by shamt
- 110 ROR: a rotated right by shamt
- 111 PASS: a
REQ-014 FSM states IDLE, ITER, DONE; ready_o SHALL be 1 only in IDLE; valid_o SHALL be 1 only in DONE.
REQ-015 IDLE, transfer, funct in {000,001,010,111}, or any op with shamt=0: result loaded same edge, go to DONE; latency 1 cycle.
REQ-016 IDLE, transfer, funct in {011..110}, shamt!=0: load 2*WIDTH work register ({a,b} funnel, {a,a} rotate), remaining count = shamt, direction per op, go to ITER.
REQ-017 ITER, each edge: work shifted by min(STEP, remaining), remaining decremented by same amount.
REQ-018 ITER, edge where remaining reaches 0: result = extracted word (low half for FSHR/ROR, high half for FSHL/ROL), go to DONE; total latency 1 + ceil(shamt/STEP) cycles.
REQ-019 shamt=0 results: FSHR -> b; FSHL, ROL, ROR -> a.
REQ-020 DONE: result and valid_o SHALL hold stable until ready_i=1; on that edge go to IDLE, valid_o low next cycle.
REQ-021 valid_i, a, b, shamt, funct SHALL be ignored outside IDLE; operands captured only at the transfer edge.
REQ-022 No back-to-back issue: minimum spacing between accepts is latency + 1 cycle.
REQ-023 Per-op results SHALL equal the REQ-013 reference formula for every WIDTH/STEP combination.

Reset
REQ-024 reset=1 on a rising edge: state=IDLE, result=0, valid_o=0, work register and count=0; ready_o=1 in the following cycle.
REQ-025 reset SHALL take priority over all activity, including mid-ITER and in DONE with ready_i=0; an in-flight op is discarded, no valid_o pulse.

Verification (WIDTH=32, STEP=4)
REQ-026 SHL a=0x00000001 shamt=31 -> result 0x80000000, valid_o first high 1 cycle after accept.
REQ-027 ASHR a=0x80000000 shamt=4 -> 0xF8000000; SHR same inputs -> 0x08000000; both latency 1.
REQ-028 FSHR a=0x12345678 b=0x9ABCDEF0 shamt=8 -> 0x789ABCDE, latency 3; FSHL same inputs -> 0x3456789A, latency 3.
REQ-029 ROL a=0x80000001 shamt=5 -> 0x00000030, latency 3; ROR a=0x00000001 shamt=0 -> 0x00000001, latency 1.
REQ-030 Backpressure: ready_i=0 for 5 cycles in DONE while valid_i toggles with new operands -> result, valid_o stable, ready_o=0, no new op captured; ready_i=1 -> IDLE next cycle.
REQ-031 reset asserted during ITER of ROR shamt=31 -> next cycle valid_o=0, result=0, ready_o=1; following op completes correctly.
